// File: rtl/riscv_imem_pkg.sv
// rtl/riscv_imem_pkg.sv - shared constants and types for the instruction memory
// Contents: NOP_INSTR (addi x0,x0,0), fault_code_t response fault codes,
//           state_t loader/run mode of the memory.
package riscv_imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10
    } fault_code_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction RAM, one write port and one registered read port
// Ports: clk; we/wr_addr/wr_data write port; rd_en/rd_addr read request;
//        rd_data registered read data, updated only when rd_en is high so it
//        holds the last read otherwise.
module imem_array #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_mem_pipe.sv
// rtl/instr_mem_pipe.sv - instruction memory with loader port, fetch handshake and fault NOPs
// Ports: clk, reset (async, active-high);
//        prog_en/prog_we/prog_addr/prog_data/prog_done loader interface;
//        fetch_req/fetch_addr/fetch_ready fetch request side, stall from decode;
//        fetch_valid/instruction/pc_out/fault/fault_code response side.
module instr_mem_pipe
    import riscv_imem_pkg::*;
#(
    parameter int                          WORDSIZE         = 64,
    parameter int                          INSTRUCTION_SIZE = 32,
    parameter int                          DEPTH            = 1024,
    parameter logic [INSTRUCTION_SIZE-1:0] NOP_INSTR        = riscv_imem_pkg::NOP_INSTR,
    parameter int                          AW               = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        prog_en,
    input  logic                        prog_we,
    input  logic [AW-1:0]               prog_addr,
    input  logic [INSTRUCTION_SIZE-1:0] prog_data,
    input  logic                        prog_done,
    input  logic                        fetch_req,
    input  logic [WORDSIZE-1:0]         fetch_addr,
    input  logic                        stall,
    output logic                        fetch_ready,
    output logic                        fetch_valid,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic [WORDSIZE-1:0]         pc_out,
    output logic                        fault,
    output logic [1:0]                  fault_code
);

    // First byte address past the array; compared over the full PC width so
    // high address bits can never alias back into the array.
    localparam logic [WORDSIZE-1:0] ADDR_LIMIT = WORDSIZE'(DEPTH) << 2;

    state_t                        state;
    state_t                        state_nxt;
    logic                          mem_we;
    logic                          accept;
    logic                          take;
    logic                          misalign;
    logic                          out_of_range;
    logic                          resp_mem;
    fault_code_t                   fc_q;
    logic [INSTRUCTION_SIZE-1:0]   rd_data;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (prog_done) state_nxt = ST_RUN;
            ST_RUN:  if (prog_en)   state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_we      = 1'b0;
        fetch_ready = 1'b0;
        case (state)
            ST_LOAD: mem_we      = prog_we;
            ST_RUN:  fetch_ready = !(fetch_valid && stall);
            default: ;
        endcase
    end

    assign accept       = fetch_req && fetch_ready;
    // An accept on the RUN->LOAD edge is dropped along with any response.
    assign take         = accept && !prog_en;
    assign misalign     = |fetch_addr[1:0];
    assign out_of_range = fetch_addr >= ADDR_LIMIT;

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (INSTRUCTION_SIZE)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (take && !misalign && !out_of_range),
        .rd_addr (fetch_addr[AW+1:2]),
        .rd_data (rd_data)
    );

    // Response registers. The RAM read register is not reset, so resp_mem
    // selects between it and the NOP; clearing resp_mem on reset makes the
    // instruction output read NOP immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            pc_out      <= '0;
            fault       <= 1'b0;
            fc_q        <= FC_NONE;
            resp_mem    <= 1'b0;
        end else begin
            if (state == ST_LOAD || prog_en) begin
                fetch_valid <= 1'b0;
            end else if (fetch_valid && stall) begin
                fetch_valid <= 1'b1;
            end else begin
                fetch_valid <= accept;
            end

            if (take) begin
                pc_out <= fetch_addr;
                if (misalign) begin
                    fault    <= 1'b1;
                    fc_q     <= FC_MISALIGN;
                    resp_mem <= 1'b0;
                end else if (out_of_range) begin
                    fault    <= 1'b1;
                    fc_q     <= FC_RANGE;
                    resp_mem <= 1'b0;
                end else begin
                    fault    <= 1'b0;
                    fc_q     <= FC_NONE;
                    resp_mem <= 1'b1;
                end
            end
        end
    end

    assign instruction = resp_mem ? rd_data : NOP_INSTR;
    assign fault_code  = fc_q;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// tb/tb_instr_mem_pipe.sv - directed self-checking bench for instr_mem_pipe
module tb_instr_mem_pipe;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        prog_en;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;
    logic        prog_done;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] instruction;
    logic [63:0] pc_out;
    logic        fault;
    logic [1:0]  fault_code;

    int errors = 0;
    int checks = 0;

    instr_mem_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .prog_en     (prog_en),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_done   (prog_done),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .instruction (instruction),
        .pc_out      (pc_out),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic [31:0] ins,
                            input logic [63:0] pc, input logic f, input logic [1:0] fc);
        chk({tag, "_valid"}, 64'(fetch_valid), 64'(v));
        chk({tag, "_instr"}, 64'(instruction), 64'(ins));
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_fault"}, 64'(fault), 64'(f));
        chk({tag, "_code"}, 64'(fault_code), 64'(fc));
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d, input logic done);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        prog_done = done;
        tick();
        prog_we   = 1'b0;
        prog_done = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        prog_en    = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        prog_done  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        stall      = 1'b0;
        #2;
        chk_resp("reset", 1'b0, NOP, 64'h0, 1'b0, 2'b00);
        tick();
        reset = 1'b0;

        // Fetch while still in LOAD is refused
        fetch_req  = 1'b1;
        fetch_addr = 64'h0;
        #1;
        chk("load_ready", 64'(fetch_ready), 64'h0);
        tick();
        chk("load_valid", 64'(fetch_valid), 64'h0);
        fetch_req = 1'b0;

        // Load program; last write coincides with prog_done
        load(10'd0,    32'h00002083, 1'b0);
        load(10'd1,    32'h08002103, 1'b0);
        load(10'd1023, 32'h00C00093, 1'b0);
        load(10'd2,    32'h00100193, 1'b1);
        #1;
        chk("run_ready", 64'(fetch_ready), 64'h1);

        fetch(64'h0);
        chk_resp("f0", 1'b1, 32'h00002083, 64'h0, 1'b0, 2'b00);
        fetch(64'h4);
        chk_resp("f4", 1'b1, 32'h08002103, 64'h4, 1'b0, 2'b00);
        fetch(64'h8);
        chk_resp("f8_same_cycle_write", 1'b1, 32'h00100193, 64'h8, 1'b0, 2'b00);

        // Faults
        fetch(64'h6);
        chk_resp("mis", 1'b1, NOP, 64'h6, 1'b1, 2'b01);
        fetch(64'h1000);
        chk_resp("range", 1'b1, NOP, 64'h1000, 1'b1, 2'b10);
        fetch(64'hFFC);
        chk_resp("last", 1'b1, 32'h00C00093, 64'hFFC, 1'b0, 2'b00);
        fetch(64'h1_0000_0000);
        chk_resp("high", 1'b1, NOP, 64'h1_0000_0000, 1'b1, 2'b10);
        fetch(64'h1002);
        chk_resp("prio", 1'b1, NOP, 64'h1002, 1'b1, 2'b01);

        // Idle: valid drops, payload holds
        fetch_req = 1'b0;
        tick();
        chk_resp("idle", 1'b0, NOP, 64'h1002, 1'b1, 2'b01);

        // Stall hold
        fetch(64'h0);
        chk_resp("st0", 1'b1, 32'h00002083, 64'h0, 1'b0, 2'b00);
        stall      = 1'b1;
        fetch_addr = 64'h4;
        #1;
        chk("st_ready", 64'(fetch_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_resp("st_hold", 1'b1, 32'h00002083, 64'h0, 1'b0, 2'b00);
        end
        stall = 1'b0;
        tick();
        chk_resp("st4", 1'b1, 32'h08002103, 64'h4, 1'b0, 2'b00);
        fetch(64'h8);
        chk_resp("st8", 1'b1, 32'h00100193, 64'h8, 1'b0, 2'b00);

        // RUN -> LOAD drops the response, reload word 0
        prog_en = 1'b1;
        tick();
        chk("reload_valid", 64'(fetch_valid), 64'h0);
        prog_en   = 1'b0;
        fetch_req = 1'b0;
        load(10'd0, 32'h40208133, 1'b0);
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        fetch(64'h0);
        chk_resp("reload0", 1'b1, 32'h40208133, 64'h0, 1'b0, 2'b00);

        // Loader write in RUN is ignored
        prog_we   = 1'b1;
        prog_addr = 10'd1;
        prog_data = 32'hDEADBEEF;
        fetch(64'h4);
        prog_we = 1'b0;
        fetch(64'h4);
        chk_resp("run_we", 1'b1, 32'h08002103, 64'h4, 1'b0, 2'b00);

        // Async reset between edges
        fetch_addr = 64'h0;
        #2;
        reset = 1'b1;
        #1;
        chk_resp("areset", 1'b0, NOP, 64'h0, 1'b0, 2'b00);
        chk("areset_ready", 64'(fetch_ready), 64'h0);
        #1;
        reset     = 1'b0;
        fetch_req = 1'b0;
        tick();
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        fetch(64'h4);
        chk_resp("keep4", 1'b1, 32'h08002103, 64'h4, 1'b0, 2'b00);
        fetch(64'h0);
        chk_resp("keep0", 1'b1, 32'h40208133, 64'h0, 1'b0, 2'b00);
        fetch_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_pipe.md
Name: instr_mem_pipe

Overview:
- Next-generation instruction memory for the RISC-V core: parametrised depth/widths, byte-addressed PC, registered (1-cycle) read with fetch handshake and stall hold.
- Writable by a boot loader port before execution; flags misaligned and out-of-range fetches and returns a NOP in their place.
- Sits between the PC/fetch stage and the decode stage.

Parameters:
- WORDSIZE, 64, PC/address width in bits.
- INSTRUCTION_SIZE, 32, instruction width in bits.
- DEPTH, 1024, number of instruction words; power of two, at least 2.
- NOP_INSTR, 32'h00000013, value returned on fault or reset (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_en  in  1  request to enter LOAD mode from RUN.
- prog_we  in  1  loader write strobe; honoured in LOAD only.
- prog_addr  in  log2(DEPTH)  loader word index.
- prog_data  in  INSTRUCTION_SIZE  loader write data.
- prog_done  in  1  loader finished; LOAD to RUN.
- fetch_req  in  1  fetch request.
- fetch_addr  in  WORDSIZE  byte address (PC).
- stall  in  1  decode stall; hold the current response.
- fetch_ready  out  1  fetch accepted this cycle when fetch_req is also high.
- fetch_valid  out  1  response valid.
- instruction  out  INSTRUCTION_SIZE  fetched instruction.
- pc_out  out  WORDSIZE  address belonging to instruction.
- fault  out  1  response is a fault NOP.
- fault_code  out  2  00 none, 01 misaligned, 10 out of range.

Behaviour:
- Reset (async, immediate):
  - state=LOAD, fetch_valid=0, instruction=NOP_INSTR, pc_out=0, fault=0, fault_code=00.
  - Memory array is not cleared.
- FSM states:
  - LOAD: prog_done -> RUN.
  - RUN: prog_en -> LOAD.
- In LOAD:
  - prog_we writes mem[prog_addr]=prog_data at the edge.
  - fetch_ready=0; fetch_valid=0.
- prog_we and prog_done in the same cycle: the write is performed, then RUN is entered; the next-cycle fetch reads the new data.
- RUN->LOAD: fetch_valid clears on the transition edge; any response is dropped.
- prog_we in RUN is ignored.
- prog_en in LOAD has no effect.
- fetch_ready = (state==RUN) && !(fetch_valid && stall); combinational.
- Accept = fetch_req && fetch_ready. An accept at edge N gives fetch_valid=1 after edge N, carrying:
  - pc_out = fetch_addr;
  - instruction = mem[fetch_addr[log2(DEPTH)+1:2]].
- Faults, checked at accept:
  - fetch_addr[1:0] != 0 -> fault=1, code 01, instruction=NOP_INSTR.
  - else fetch_addr >= 4*DEPTH (full WORDSIZE compare) -> fault=1, code 10, NOP_INSTR.
  - Misaligned takes priority.
  - Faults are per response; no sticky state.
- Stall: fetch_valid && stall holds all outputs unchanged for every stalled cycle.
- No accept and no stall: fetch_valid=0 next cycle; instruction/pc_out/fault hold their last values.
- Back-to-back accepts give one response per cycle (throughput 1).
- Read and write of the same index cannot coincide, because writes occur only in LOAD.

Decomposition:
- Package riscv_imem_pkg holds:
  - NOP_INSTR constant;
  - fault_code enum (FC_NONE, FC_MISALIGN, FC_RANGE);
  - FSM state enum (ST_LOAD, ST_RUN).
- Sub-module imem_array: synchronous RAM, one write port and one registered read port, parametrised by DEPTH and INSTRUCTION_SIZE. Top level holds the FSM, fault logic, handshake and output/hold registers.

Test Plan:
1. Reset then load:
   - Write mem[0]=0x00002083, mem[1]=0x08002103, then prog_done.
   - Fetch 0x0: valid one cycle later, instruction=0x00002083, pc_out=0.
   - Fetch 0x4: valid one cycle later, instruction=0x08002103, pc_out=4.
2. Fetch before prog_done:
   - fetch_ready=0 and fetch_valid stays 0.
   - After prog_done, the first accept responds next cycle.
3. Misaligned and out-of-range fetches:
   - Fetch 0x6 -> fault=1, code 01, instruction=0x00000013.
   - Fetch 0x1000 with DEPTH=1024 -> fault=1, code 10.
   - Fetch 0xFFC -> mem[1023], fault=0.
4. Stall hold:
   - Stream 0x0, 0x4, 0x8 with stall high for 3 cycles after the first response.
   - Response for 0x0 is held, fetch_ready=0, and no request is lost.
   - Order resumes with 0x4 and then 0x8.
5. prog_en in RUN with a valid response:
   - fetch_valid drops next cycle; prog_we then writes mem[0]=0x40208133.
   - After prog_done, fetch 0x0 returns 0x40208133.
6. Async reset mid-stream:
   - Assert reset between edges: outputs go immediately to reset values and state is LOAD.
   - Memory contents survive and are readable after prog_done.
